fetch_queue: RTL

Parametrised instruction-fetch front end that replaces the bare PC register and stall logic feeding the decode stage.
- Owns the fetch PC and issues ibus requests (one outstanding).
- Buffers returned instructions in a DEPTH-entry queue; decode consumes them through a valid/ready handshake.
- Supports redirect and flush, including discarding an in-flight response.
- Flags misaligned fetch PCs instead of issuing them to the bus.

---
 rtl/fetch_queue_pkg.sv | 35 +++
 rtl/fetch_queue_fifo.sv | 68 ++++++
 rtl/fetch_queue.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction-fetch front end: bus payloads, queue entry, FSM state.
package fetch_queue_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    // Default fetch PC after reset
    localparam logic [XLEN-1:0] PCINIT = 64'h0000_0000_8000_0000;

    // Instruction bus request: held stable until data_ok
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] addr;
    } ibus_req_t;

    // Instruction bus response
    typedef struct packed {
        logic            data_ok;
        logic [ILEN-1:0] data;
    } ibus_resp_t;

    // One fetched instruction (or a misaligned-fetch marker)
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Generic synchronous FIFO with flush; head is read combinationally from storage.
// Ports: clk/rst_n, push_i + push_data_i, pop_i, flush_i (clears contents),
//        head_o (entry at read pointer), count_o (occupancy).
module fetch_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  entry_t                       push_data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output entry_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    // Pop only when non-empty; push only when a slot is free (or freed this cycle)
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    // Pointer / occupancy update; flush wins over push and pop
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted as valid
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding ibus
// request at a time, and queues returned instructions for decode.
// Ports: clk, reset (async active-low), ireq/iresp (instruction bus),
//        redirect_valid/redirect_pc (flush + restart), out_* (decode handshake,
//        head of queue), count (queue occupancy).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = PCINIT
) (
    input  logic                        clk,
    input  logic                        reset,
    output ibus_req_t                   ireq,
    input  ibus_resp_t                  iresp,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_pc,
    output logic [ILEN-1:0]             out_instr,
    output logic                        out_fault,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            halted_q, halted_d;

    logic            push;
    fetch_entry_t    push_entry;
    logic            flush;
    logic            pop;
    fetch_entry_t    head;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   occ_after_pop;
    logic            space;
    logic            space_after_push;
    logic [XLEN-1:0] next_addr;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    // Space is judged after this cycle's pop so a full queue can refill immediately
    assign pop              = out_valid && out_ready;
    assign occ_after_pop    = fifo_count - CW'(pop);
    assign space            = occ_after_pop < CW'(DEPTH);
    assign space_after_push = occ_after_pop < CW'(DEPTH - 1);
    assign next_addr        = req_addr_q + 64'd4;

    // State register (with PC / request address / halt flag)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            halted_q   <= halted_d;
        end
    end

    // Next-state: redirect has priority over everything else
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        halted_d   = halted_q;
        push       = 1'b0;
        push_entry = '0;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush    = 1'b1;
            pc_d     = redirect_pc;
            halted_d = 1'b0;
            case (state_q)
                // An in-flight request must complete on the bus; its data is dropped
                REQ, DROP: state_d = iresp.data_ok ? IDLE : DROP;
                default:   state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (!halted_q && space) begin
                        if (pc_q[1:0] == 2'b00) begin
                            state_d    = REQ;
                            req_addr_d = pc_q;
                        end else begin
                            // Misaligned PC: queue a fault marker and stop fetching
                            push             = 1'b1;
                            push_entry.pc    = pc_q;
                            push_entry.instr = '0;
                            push_entry.fault = 1'b1;
                            halted_d         = 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (iresp.data_ok) begin
                        push             = 1'b1;
                        push_entry.pc    = req_addr_q;
                        push_entry.instr = iresp.data;
                        push_entry.fault = 1'b0;
                        pc_d             = next_addr;
                        if (space_after_push && (next_addr[1:0] == 2'b00) && !halted_q) begin
                            req_addr_d = next_addr;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (iresp.data_ok) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Bus outputs: DROP looks identical to REQ on the bus
    always_comb begin
        ireq       = '0;
        ireq.valid = (state_q == REQ) || (state_q == DROP);
        ireq.addr  = req_addr_q;
    end

    // Decode outputs: head entry, forced to zero while the queue is empty
    always_comb begin
        out_valid = (fifo_count != '0);
        out_pc    = out_valid ? head.pc    : '0;
        out_instr = out_valid ? head.instr : '0;
        out_fault = out_valid ? head.fault : 1'b0;
        count     = fifo_count;
    end

endmodule
